// File: rtl/apb_irq_controller.sv
// APB interrupt controller: NUM_IRQS synchronous sources with per-source edge/level
// detection, sticky W1C pending bits, enable mask, software set, lowest-index priority
// encode and a holdoff timer that spaces successive assertions of the irq pin.
module apb_irq_controller #(
    parameter int          NUM_IRQS      = 8,
    parameter logic [31:0] EDGE_INIT     = 32'h0,
    parameter int          HOLDOFF_WIDTH = 16
) (
    input  logic                pclk,
    input  logic                preset_n,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [9:0]          paddr,
    input  logic [31:0]         pwdata,
    output logic [31:0]         prdata,
    output logic                pready,
    output logic                pslverr,
    input  logic [NUM_IRQS-1:0] irq_src,
    output logic                irq
);

    typedef enum logic [2:0] {
        REG_RAW     = 3'd0,
        REG_PENDING = 3'd1,
        REG_ENABLE  = 3'd2,
        REG_MODE    = 3'd3,
        REG_SET     = 3'd4,
        REG_ACTIVE  = 3'd5,
        REG_HIGHEST = 3'd6,
        REG_HOLDOFF = 3'd7
    } reg_word_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ASSERT,
        ST_HOLDOFF
    } irq_state_t;

    logic [NUM_IRQS-1:0]      pending, enable, mode, src_ff;
    logic [NUM_IRQS-1:0]      active, set_hw, sw_set, w1c;
    logic [HOLDOFF_WIDTH-1:0] holdoff, count;
    logic [4:0]               hi_idx;
    logic [31:0]              rdata;
    reg_word_t                word;
    irq_state_t               state;
    logic                     access, addr_bad, ro_word, err, wr_ok;
    logic                     unused_bits;

    // Address decode; byte offset bits and data bits beyond the register widths are ignored.
    assign word        = reg_word_t'(paddr[4:2]);
    assign addr_bad    = |paddr[9:5];
    assign ro_word     = (word == REG_RAW) || (word == REG_ACTIVE) || (word == REG_HIGHEST);
    assign err         = addr_bad || (pwrite && ro_word);
    assign access      = psel && penable && !pready;
    assign wr_ok       = access && pwrite && !err;
    assign unused_bits = ^{pwdata, paddr[1:0]};

    // Edge sources pend on a 0->1 step, level sources on every high cycle.
    assign set_hw = irq_src & (~mode | ~src_ff);
    assign sw_set = (wr_ok && word == REG_SET)     ? pwdata[NUM_IRQS-1:0] : '0;
    assign w1c    = (wr_ok && word == REG_PENDING) ? pwdata[NUM_IRQS-1:0] : '0;
    assign active = pending & enable;

    // Lowest-index active source wins: scan downwards so the last hit is the smallest index.
    always_comb begin
        // NOTE: every variable gets a default before the branches so no latch is inferred.
        hi_idx = '0;
        for (int i = NUM_IRQS - 1; i >= 0; i--) begin
            if (active[i]) hi_idx = 5'(i);
        end
    end

    // Read multiplexer for the addressed word.
    always_comb begin
        rdata = '0;
        case (word)
            REG_RAW:     rdata = 32'(irq_src);
            REG_PENDING: rdata = 32'(pending);
            REG_ENABLE:  rdata = 32'(enable);
            REG_MODE:    rdata = 32'(mode);
            REG_SET:     rdata = '0;
            REG_ACTIVE:  rdata = 32'(active);
            REG_HIGHEST: rdata = {|active, 26'd0, hi_idx};
            REG_HOLDOFF: rdata = 32'(holdoff);
            default:     rdata = '0;
        endcase
    end

    // APB response: one wait state, a single-cycle pready carrying prdata/pslverr.
    always_ff @(posedge pclk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!preset_n) begin
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
        end else if (access) begin
            pready  <= 1'b1;
            pslverr <= err;
            prdata  <= (!pwrite && !err) ? rdata : '0;
        end else begin
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
        end
    end

    // Register file and pending capture; a set in the same cycle as W1C keeps the bit.
    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            pending <= '0;
            enable  <= '0;
            mode    <= EDGE_INIT[NUM_IRQS-1:0];
            holdoff <= '0;
            src_ff  <= '0;
        end else begin
            src_ff  <= irq_src;
            pending <= (pending & ~w1c) | set_hw | sw_set;
            if (wr_ok) begin
                case (word)
                    REG_ENABLE:  enable  <= pwdata[NUM_IRQS-1:0];
                    REG_MODE:    mode    <= pwdata[NUM_IRQS-1:0];
                    REG_HOLDOFF: holdoff <= pwdata[HOLDOFF_WIDTH-1:0];
                    default:     ;
                endcase
            end
        end
    end

    // irq sequencer: assert while anything is active, then stay quiet for the holdoff time.
    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            state <= ST_IDLE;
            count <= '0;
            irq   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|active) begin
                        state <= ST_ASSERT;
                        irq   <= 1'b1;
                    end
                end
                ST_ASSERT: begin
                    if (active == '0) begin
                        irq   <= 1'b0;
                        count <= holdoff;
                        state <= (holdoff == '0) ? ST_IDLE : ST_HOLDOFF;
                    end
                end
                ST_HOLDOFF: begin
                    count <= count - 1'b1;
                    if (count == HOLDOFF_WIDTH'(1)) state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    irq   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_irq_controller.sv
// Bench for apb_irq_controller: a per-cycle behavioural model of the register map and
// irq timing is compared with the DUT outputs every cycle, alongside directed scenarios
// whose expected register values are written out by hand.
module tb_apb_irq_controller;

    localparam int N = 8;

    logic        pclk = 1'b0;
    logic        preset_n, psel, penable, pwrite;
    logic [9:0]  paddr;
    logic [31:0] pwdata, prdata;
    logic        pready, pslverr, irq;
    logic [N-1:0] irq_src;

    int n_pass  = 0;
    int n_total = 0;

    apb_irq_controller #(.NUM_IRQS(N), .EDGE_INIT(32'h0), .HOLDOFF_WIDTH(16)) dut (
        .pclk(pclk), .preset_n(preset_n), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .irq_src(irq_src), .irq(irq)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Behavioural model: register contents plus an irq flag and a quiet-time countdown.
    logic [N-1:0] m_pend, m_en, m_mode, m_prev;
    int           m_hold, m_quiet;
    logic         m_irq, m_pready, m_pslverr;
    logic [31:0]  m_prdata;
    bit           model_live = 0;

    always @(posedge pclk) begin
        logic [N-1:0] act, set, clr, sw, low;
        int           w;
        bit           bad, ro, err;
        if (!preset_n) begin
            m_pend = '0; m_en = '0; m_mode = '0; m_prev = '0;
            m_hold = 0; m_quiet = 0; m_irq = 0;
            m_pready = 0; m_pslverr = 0; m_prdata = '0;
            model_live = 1;
        end else begin
            act = m_pend & m_en;
            if (m_irq) begin
                if (act == 0) begin m_irq = 0; m_quiet = m_hold; end
            end else if (m_quiet > 0) m_quiet--;
            else if (act != 0) m_irq = 1;

            for (int i = 0; i < N; i++)
                set[i] = m_mode[i] ? (irq_src[i] && !m_prev[i]) : irq_src[i];
            clr = '0; sw = '0;
            if (psel && penable && !m_pready) begin
                w   = int'(paddr[4:2]);
                bad = (paddr >= 10'h20);
                ro  = (w == 0) || (w == 5) || (w == 6);
                err = bad || (pwrite && ro);
                m_pready = 1; m_pslverr = err; m_prdata = '0;
                if (!pwrite && !err) begin
                    case (w)
                        0: m_prdata = 32'(irq_src);
                        1: m_prdata = 32'(m_pend);
                        2: m_prdata = 32'(m_en);
                        3: m_prdata = 32'(m_mode);
                        5: m_prdata = 32'(act);
                        6: begin
                            low = act & (~act + 8'd1);
                            m_prdata = (act == 0) ? 32'h0 : (32'h8000_0000 | 32'($clog2(low)));
                        end
                        7: m_prdata = 32'(m_hold);
                        default: m_prdata = '0;
                    endcase
                end
                if (pwrite && !err) begin
                    case (w)
                        1: clr    = pwdata[N-1:0];
                        2: m_en   = pwdata[N-1:0];
                        3: m_mode = pwdata[N-1:0];
                        4: sw     = pwdata[N-1:0];
                        7: m_hold = int'(pwdata[15:0]);
                        default: ;
                    endcase
                end
            end else begin
                m_pready = 0; m_pslverr = 0; m_prdata = '0;
            end
            m_pend = (m_pend & ~clr) | set | sw;
            m_prev = irq_src;
        end
    end

    // Every cycle after the first reset edge the outputs must match the model.
    always @(negedge pclk) begin
        if (model_live)
            check("cycle_outputs", {29'd0, irq, pready, pslverr, prdata},
                  {29'd0, m_irq, m_pready, m_pslverr, m_prdata});
    end

    task automatic apb_xfer(input bit wr, input logic [9:0] addr, input logic [31:0] data,
                            output logic [31:0] rd, output logic err);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
        @(negedge pclk);
        penable = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge pclk);
            if (pready) break;
        end
        if (!pready) check("apb_timeout", {63'd0, pready}, 64'd1);
        rd = prdata; err = pslverr;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_write(input logic [9:0] addr, input logic [31:0] data);
        logic [31:0] rd;
        logic        e;
        apb_xfer(1'b1, addr, data, rd, e);
    endtask

    task automatic read_check(input string name, input logic [9:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        logic        e;
        apb_xfer(1'b0, addr, 32'h0, rd, e);
        check(name, {32'd0, rd}, {32'd0, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          low;
        logic [31:0] rd;
        logic        e;
        preset_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; irq_src = '0;
        repeat (3) @(negedge pclk);
        preset_n = 1'b1;

        // Reset state.
        check("reset_irq", {63'd0, irq}, 64'd0);
        read_check("reset_pending", 10'h04, 32'h0);
        read_check("reset_mode", 10'h0c, 32'h0);
        read_check("reset_holdoff", 10'h1c, 32'h0);

        // Edge source 0: pending one cycle after the pulse, irq one cycle later.
        apb_write(10'h08, 32'h01);
        apb_write(10'h0c, 32'h01);
        irq_src[0] = 1'b1;
        @(negedge pclk);
        irq_src[0] = 1'b0;
        check("edge_irq_n1", {63'd0, irq}, 64'd0);
        @(negedge pclk);
        check("edge_irq_n2", {63'd0, irq}, 64'd1);
        read_check("edge_pending", 10'h04, 32'h01);
        apb_write(10'h04, 32'h01);
        @(negedge pclk);
        check("edge_w1c_irq", {63'd0, irq}, 64'd0);

        // Level source 3 held high re-pends after W1C.
        apb_write(10'h0c, 32'h00);
        apb_write(10'h08, 32'h08);
        irq_src[3] = 1'b1;
        repeat (3) @(negedge pclk);
        check("level_irq", {63'd0, irq}, 64'd1);
        apb_write(10'h04, 32'h08);
        read_check("level_repend", 10'h04, 32'h08);
        check("level_irq_kept", {63'd0, irq}, 64'd1);
        irq_src[3] = 1'b0;
        @(negedge pclk);
        apb_write(10'h04, 32'h08);
        read_check("level_cleared", 10'h04, 32'h00);
        repeat (2) @(negedge pclk);
        check("level_irq_low", {63'd0, irq}, 64'd0);

        // Holdoff of 10: ten counting cycles plus the idle re-arm cycle before irq returns.
        apb_write(10'h08, 32'h01);
        apb_write(10'h0c, 32'h01);
        apb_write(10'h1c, 32'd10);
        read_check("holdoff_reg", 10'h1c, 32'd10);
        apb_write(10'h10, 32'h01);
        repeat (3) @(negedge pclk);
        check("holdoff_irq_on", {63'd0, irq}, 64'd1);
        apb_write(10'h04, 32'h01);
        irq_src[0] = 1'b1;
        @(negedge pclk);
        irq_src[0] = 1'b0;
        low = 0;
        while (!irq && low < 40) begin
            low++;
            @(negedge pclk);
        end
        check("holdoff_low_cycles", 64'(low), 64'd11);
        apb_write(10'h1c, 32'd0);
        apb_write(10'h04, 32'h01);

        // Software set and priority encode.
        apb_write(10'h08, 32'hFF);
        apb_write(10'h0c, 32'h00);
        apb_write(10'h10, 32'hA0);
        read_check("set_reads_zero", 10'h10, 32'h0);
        read_check("active_a0", 10'h14, 32'hA0);
        read_check("highest_5", 10'h18, 32'h8000_0005);
        apb_write(10'h04, 32'h20);
        read_check("highest_7", 10'h18, 32'h8000_0007);
        apb_write(10'h04, 32'h80);
        read_check("highest_none", 10'h18, 32'h0);

        // Edge on source 2 sampled in the same cycle its W1C lands: the set wins.
        apb_write(10'h0c, 32'h04);
        apb_write(10'h10, 32'h04);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 10'h04; pwdata = 32'h04;
        @(negedge pclk);
        penable = 1'b1;
        irq_src[2] = 1'b1;
        @(negedge pclk);
        check("race_pready", {63'd0, pready}, 64'd1);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        read_check("race_set_wins", 10'h04, 32'h04);
        irq_src[2] = 1'b0;
        apb_write(10'h04, 32'h04);
        read_check("race_cleared", 10'h04, 32'h00);

        // Error responses and unaligned access.
        apb_xfer(1'b0, 10'h24, 32'h0, rd, e);
        check("err_read_slverr", {63'd0, e}, 64'd1);
        check("err_read_data", {32'd0, rd}, 64'd0);
        apb_xfer(1'b1, 10'h14, 32'hFF, rd, e);
        check("err_write_ro", {63'd0, e}, 64'd1);
        apb_xfer(1'b1, 10'h3FC, 32'hFF, rd, e);
        check("err_write_far", {63'd0, e}, 64'd1);
        read_check("err_pending_same", 10'h04, 32'h00);
        read_check("unaligned_enable", 10'h0b, 32'hFF);

        // Reset in the access phase with irq asserted.
        apb_write(10'h10, 32'h01);
        repeat (3) @(negedge pclk);
        check("pre_reset_irq", {63'd0, irq}, 64'd1);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 10'h04;
        @(negedge pclk);
        penable = 1'b1;
        preset_n = 1'b0;
        @(negedge pclk);
        check("reset_abort_pready", {63'd0, pready}, 64'd0);
        check("reset_irq_low", {63'd0, irq}, 64'd0);
        psel = 1'b0; penable = 1'b0;
        @(negedge pclk);
        preset_n = 1'b1;
        read_check("post_reset_pending", 10'h04, 32'h0);
        read_check("post_reset_enable", 10'h08, 32'h0);

        repeat (2) @(negedge pclk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
